logic_result_buffer: RTL and testbench
======================================

Name: logic_result_buffer

Overview:
- Downstream stage of the reversible-gate logic operators (4-bit XOR/AND/OR/NOT).
- Captures each combinational 4-bit result with its opcode tag and computes zero and parity flags.
- Buffers entries in a small FIFO and presents them to the ALU output/writeback stage over a valid/ready handshake.
- Decouples the combinational logic ops from a consumer that can stall.

Parameters:
- WIDTH, 4, result width in bits; matches the logic operator width.
- OPW, 2, opcode tag width. Encoding: 00=AND, 01=OR, 10=XOR, 11=NOT.
- DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush. Empties the FIFO; pop_cnt is unchanged.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  buffer can accept an entry.
- in_op  input  OPW  opcode tag of the incoming result.
- in_res  input  WIDTH  result from the logic operator.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_op  output  OPW  head opcode tag.
- out_res  output  WIDTH  head result.
- out_zero  output  1  head result == 0.
- out_parity  output  1  XOR-reduction of the head result (1 = odd number of ones).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- pop_cnt  output  8  number of entries delivered; wraps 255->0.

Behaviour:
- Reset (async, immediate on rst rising, held while rst=1):
  - wr_ptr=0, rd_ptr=0, count=0, pop_cnt=0.
  - out_valid=0, in_ready=1, out_op/out_res/out_zero/out_parity=0.
  - Storage array contents are don't-care.
- Entry format, fixed at push:
  - {op, res, zero=~|res, parity=^res}.
  - Flags are computed on in_res at push time, never at pop.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Combinational from registered count.
  - No pass-through when full: a simultaneous pop while full does not raise in_ready in that cycle.
- out_valid = (count != 0).
  - out_* fields are read from mem[rd_ptr] (first-word fall-through).
  - When out_valid=0, out_* fields are driven to 0.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N, so it can be popped at edge N+1. Minimum latency is 1 cycle.
- Push: mem[wr_ptr] <= entry; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH; pop_cnt increments with 8-bit wrap.
- Count update:
  - push & !pop: count+1.
  - pop & !push: count-1.
  - push & pop: count unchanged. This is legal at any occupancy 1..DEPTH-1. Both pointers advance and ordering is preserved.
- Ordering is strict FIFO. Head data must be stable while out_valid=1 and out_ready=0.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count only.
- clear=1 at an edge:
  - wr_ptr=rd_ptr=0, count=0.
  - Any push or pop in that cycle is ignored; pop_cnt does not increment.
  - clear has priority over push and pop. rst has priority over everything.
- If in_valid=1 while in_ready=0, upstream holds the data. No state change, no error.
- Reset asserted mid-stream discards all entries. After rst is released, the first push is stored at index 0.

Test Plan:
- Reset check: assert rst with 3 entries queued -> count=0, out_valid=0, in_ready=1, pop_cnt=0 immediately, without waiting for a clock edge.
- Single push: op=10, res=1111 (0000 XOR 1111), out_ready=0 -> next cycle out_valid=1, out_res=1111, out_zero=0, out_parity=0, count=1. Raise out_ready -> out_valid=0, pop_cnt=1.
- Flag cases: push res=0000, 0111, 1010 -> popped in order with (zero, parity) = (1,0), (0,1), (0,0).
- Fill and backpressure: push 4 entries with out_ready=0 -> count=4, in_ready=0. Fifth in_valid is held off with no change to the queue. Drain -> values emerge in push order, last pop gives count=0.
- Simultaneous push/pop: hold count=2 with in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, pointers wrap past DEPTH, output sequence equals input sequence delayed by 2, pop_cnt=10.
- clear and pop_cnt wrap: clear with count=3 -> count=0 next cycle, pop_cnt unchanged. Stream 256 pops -> pop_cnt returns to 0.

Source files
------------

// File: rtl/logic_result_buffer.sv
// logic_result_buffer
//   Captures 4-bit results from the reversible-gate logic operators together
//   with their opcode tag. Zero and parity flags are computed at capture time.
//   Entries sit in a small first-word-fall-through FIFO that feeds the
//   writeback stage over a valid/ready handshake.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   clear            synchronous flush (empties FIFO, keeps pop_cnt)
//   in_valid/ready   upstream handshake; in_op, in_res are the payload
//   out_valid/ready  downstream handshake
//   out_op, out_res, out_zero, out_parity   head entry (zero when empty)
//   count            occupancy 0..DEPTH
//   pop_cnt          delivered-entry counter, 8-bit wrap
module logic_result_buffer #(
  parameter int WIDTH = 4,
  parameter int OPW   = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           in_op,
  input  logic [WIDTH-1:0]         in_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPW-1:0]           out_op,
  output logic [WIDTH-1:0]         out_res,
  output logic                     out_zero,
  output logic                     out_parity,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               pop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             parity;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  entry_t          head;

  // Readiness comes from the registered count only, so a pop while full
  // does not open a slot in the same cycle.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head       = mem[rd_ptr];
  assign out_op     = out_valid ? head.op     : '0;
  assign out_res    = out_valid ? head.res    : '0;
  assign out_zero   = out_valid ? head.zero   : 1'b0;
  assign out_parity = out_valid ? head.parity : 1'b0;

  // Storage has no reset; its contents only matter once count says so.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= '{op: in_op, res: in_res, zero: ~|in_res, parity: ^in_res};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pop_cnt <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        pop_cnt <= pop_cnt + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_result_buffer.sv
// Randomized and directed bench for logic_result_buffer, checked against a
// queue-based reference model.
module tb_logic_result_buffer;

  localparam int WIDTH = 4;
  localparam int OPW   = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, clear, in_valid, in_ready, out_valid, out_ready;
  logic [OPW-1:0]   in_op, out_op;
  logic [WIDTH-1:0] in_res, out_res;
  logic             out_zero, out_parity;
  logic [2:0]       count;
  logic [7:0]       pop_cnt;

  logic_result_buffer #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_res(in_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_res(out_res), .out_zero(out_zero), .out_parity(out_parity),
    .count(count), .pop_cnt(pop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int res;
  } ent_t;

  ent_t m_q[$];
  int   m_pcnt;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output against the model state.
  task automatic chk_state(input string tag);
    int hop, hres, hz, hp;
    hop = 0; hres = 0; hz = 0; hp = 0;
    if (m_q.size() > 0) begin
      hop  = m_q[0].op;
      hres = m_q[0].res;
      hz   = (hres == 0) ? 1 : 0;
      hp   = $countones(hres) % 2;
    end
    chk({tag, ".count"},     int'(count),     m_q.size());
    chk({tag, ".out_valid"}, int'(out_valid), (m_q.size() > 0) ? 1 : 0);
    chk({tag, ".in_ready"},  int'(in_ready),  (m_q.size() < DEPTH) ? 1 : 0);
    chk({tag, ".pop_cnt"},   int'(pop_cnt),   m_pcnt);
    chk({tag, ".out_op"},    int'(out_op),    hop);
    chk({tag, ".out_res"},   int'(out_res),   hres);
    chk({tag, ".out_zero"},  int'(out_zero),  hz);
    chk({tag, ".out_parity"},int'(out_parity),hp);
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
  task automatic step(input string tag, input logic v, input int op, input int res,
                      input logic rdy, input logic clr);
    bit do_push, do_pop;
    in_valid  = v;
    in_op     = OPW'(op);
    in_res    = WIDTH'(res);
    out_ready = rdy;
    clear     = clr;
    @(negedge clk);
    chk_state(tag);
    do_push = v && (m_q.size() < DEPTH);
    do_pop  = rdy && (m_q.size() > 0);
    if (clr) begin
      m_q.delete();
    end else begin
      if (do_pop) begin
        void'(m_q.pop_front());
        m_pcnt = (m_pcnt + 1) % 256;
      end
      if (do_push) m_q.push_back('{op, res});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pcnt = 0;
  endtask

  int base;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_res = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_state("reset");

    // Single push: XOR result 1111.
    step("single_push", 1, 2, 4'hF, 0, 0);
    step("single_hold", 0, 0, 0, 0, 0);
    step("single_pop", 0, 0, 0, 1, 0);
    step("single_done", 0, 0, 0, 0, 0);

    // Flag cases.
    step("flag_p0", 1, 0, 4'h0, 0, 0);
    step("flag_p1", 1, 1, 4'h7, 0, 0);
    step("flag_p2", 1, 2, 4'hA, 0, 0);
    for (int i = 0; i < 4; i++) step("flag_pop", 0, 0, 0, 1, 0);

    // Fill, backpressure on the fifth push, then drain.
    for (int i = 0; i < 4; i++) step("fill", 1, i, 4'h3 + i * 3, 0, 0);
    step("full_hold", 1, 3, 4'h9, 0, 0);
    step("full_pop", 1, 3, 4'h9, 1, 0);   // in_ready stays low while full
    for (int i = 0; i < 5; i++) step("drain", 0, 0, 0, 1, 0);

    // Steady state push+pop at count=2, pointers wrap.
    step("pp_pre0", 1, 1, 4'h1, 0, 0);
    step("pp_pre1", 1, 2, 4'h2, 0, 0);
    base = m_pcnt;
    for (int i = 0; i < 10; i++) step("pushpop", 1, i % 4, (i + 5) % 16, 1, 0);
    chk("pushpop.count", int'(count), 2);
    chk("pushpop.pop_delta", (int'(pop_cnt) - base + 256) % 256, 10);

    // Clear with count=3; push/pop in the same cycle are ignored.
    step("clr_pre", 1, 3, 4'hC, 0, 0);
    base = m_pcnt;
    step("clear", 1, 0, 4'h5, 1, 1);
    step("after_clear", 0, 0, 0, 0, 0);
    chk("clear.pop_cnt_kept", int'(pop_cnt), base);

    // 256 pops bring pop_cnt back around.
    step("wrap_pre", 1, 0, 4'h8, 0, 0);
    base = int'(pop_cnt);
    for (int i = 0; i < 256; i++) step("wrap", 1, i % 4, i % 16, 1, 0);
    chk("wrap.pop_cnt", int'(pop_cnt), base);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 40) == 0));
    end

    // Asynchronous reset with 3 entries queued, checked between edges.
    step("rst_pre", 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("rst_fill", 1, i, i + 9, 0, 0);
    chk("rst_pre.count", int'(count), 3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_state("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    step("post_rst_push", 1, 3, 4'h6, 0, 0);
    step("post_rst_pop", 0, 0, 0, 1, 0);
    step("post_rst_end", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
